seq_match_logger: RTL and testbench

Downstream consumer of the 1010 Mealy sequence detector output Y. It samples the detector's 1-cycle match pulse, keeps a saturating match count, and timestamps every match into a small FIFO that the host drains. It also raises a sticky threshold interrupt. It sits between the detector and the host/register interface.

---
 rtl/seq_match_logger.sv | 175 +++++++++++++++++
 tb/tb_seq_match_logger.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_logger.sv
// -----------------------------------------------------------------------------
// seq_match_logger
//
// Logs match pulses from a 1010 sequence detector. Every sampled high cycle of
// det_in while en=1 is one event. Each event is counted in a saturating
// counter, and the free-running timestamp is pushed into a show-ahead FIFO
// that the host drains. A sticky interrupt fires when the count reaches the
// programmed threshold.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   det_in     detector match output (already in the clk domain)
//   en         logging enable; gates event capture and timestamp advance
//   thr        interrupt threshold (0 disables the interrupt)
//   clr        clears match_cnt, overflow and irq (FIFO untouched)
//   rd_en      pop request; ignored while the FIFO is empty
//   rd_data    timestamp at the FIFO head (0 when empty)
//   rd_valid   FIFO non-empty
//   fifo_count number of stored entries, 0..DEPTH
//   match_cnt  saturating count of accepted events
//   overflow   sticky: an event was dropped because the FIFO was full
//   irq        sticky: match_cnt reached thr
// -----------------------------------------------------------------------------
module seq_match_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det_in,
    input  logic                     en,
    input  logic [CNT_W-1:0]         thr,
    input  logic                     clr,
    input  logic                     rd_en,
    output logic [TS_W-1:0]          rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     overflow,
    output logic                     irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic {
        IRQ_IDLE  = 1'b0,
        IRQ_FIRED = 1'b1
    } irq_state_t;

    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic             ev;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             hit;

    irq_state_t irq_state;
    irq_state_t irq_state_next;

    // -------------------------------------------------------------------------
    // Event and FIFO control
    // -------------------------------------------------------------------------
    assign ev     = en & det_in;
    assign full   = (count == FULL_COUNT);
    // A pop needs an entry that existed before this edge, so a push into an
    // empty FIFO with rd_en=1 is not popped in the same cycle.
    assign do_pop = rd_en && (count != '0);
    // When full, a simultaneous pop frees the slot the push needs.
    assign do_push = ev && (!full || do_pop);
    assign drop    = ev && full && !do_pop;

    // clr wipes the old count first, so a same-cycle event becomes the first.
    assign cnt_base = clr ? '0 : match_cnt;
    assign cnt_next = (ev && (cnt_base != CNT_MAX)) ? cnt_base + 1'b1 : cnt_base;
    assign hit      = ev && (thr != '0) && (cnt_next == thr);

    // -------------------------------------------------------------------------
    // Timestamp, pointers, occupancy
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (en) begin
                ts <= ts + 1'b1;
            end
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count and
    // rd_data is masked while empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[wr_ptr] <= ts;
        end
    end

    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

    // -------------------------------------------------------------------------
    // Match counter and sticky overflow
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            match_cnt <= cnt_next;
            // A drop in the same cycle as clr still leaves overflow set.
            overflow  <= (overflow && !clr) || drop;
        end
    end

    // -------------------------------------------------------------------------
    // Interrupt FSM: state register / next state / output
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_state <= IRQ_IDLE;
        end else begin
            irq_state <= irq_state_next;
        end
    end

    // NOTE: the default assignment at the top keeps this block latch-free.
    always_comb begin
        irq_state_next = irq_state;
        if (clr) begin
            // hit here can only mean thr==1 with a same-cycle event.
            irq_state_next = hit ? IRQ_FIRED : IRQ_IDLE;
        end else begin
            unique case (irq_state)
                IRQ_IDLE:  if (hit) irq_state_next = IRQ_FIRED;
                IRQ_FIRED: irq_state_next = IRQ_FIRED;
                default:   irq_state_next = IRQ_IDLE;
            endcase
        end
    end

    always_comb begin
        irq = (irq_state == IRQ_FIRED);
    end

endmodule

// File: tb/tb_seq_match_logger.sv
// -----------------------------------------------------------------------------
// Testbench for seq_match_logger. Two instances share the same inputs: the
// default configuration (TS_W=16) and a narrow-timestamp one (TS_W=4) so the
// timestamp wrap is reached quickly. A queue-based reference model predicts
// every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_seq_match_logger;

    localparam int TS_W    = 16;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             det_in = 1'b0;
    logic             en = 1'b0;
    logic [CNT_W-1:0] thr = '0;
    logic             clr = 1'b0;
    logic             rd_en = 1'b0;

    logic [TS_W-1:0]  rd_data;
    logic             rd_valid;
    logic [2:0]       fifo_count;
    logic [CNT_W-1:0] match_cnt;
    logic             overflow;
    logic             irq;

    logic [3:0]       rd_data_s;
    logic             rd_valid_s;
    logic [2:0]       fifo_count_s;
    logic [CNT_W-1:0] match_cnt_s;
    logic             overflow_s;
    logic             irq_s;

    seq_match_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .det_in(det_in), .en(en), .thr(thr), .clr(clr),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_count(fifo_count), .match_cnt(match_cnt), .overflow(overflow),
        .irq(irq)
    );

    seq_match_logger #(.TS_W(4), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut_s (
        .clk(clk), .rst(rst), .det_in(det_in), .en(en), .thr(thr), .clr(clr),
        .rd_en(rd_en), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
        .fifo_count(fifo_count_s), .match_cnt(match_cnt_s), .overflow(overflow_s),
        .irq(irq_s)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_q[$];
    int m_ts;
    int m_cnt;
    bit m_ov;
    bit m_irq;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit ev;
        if (!rst) begin
            m_q.delete();
            m_ts  = 0;
            m_cnt = 0;
            m_ov  = 0;
            m_irq = 0;
        end else begin
            ev = en && det_in;
            if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
            if (ev) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ts);
                else m_ov = 1;
            end
            if (clr) begin
                m_cnt = 0;
                m_irq = 0;
                // a drop in this cycle was recorded above and must survive clr
                if (!(ev && m_q.size() == DEPTH && !(rd_en) && m_ov)) m_ov = m_ov;
            end
            if (ev) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                if (thr != 0 && m_cnt == int'(thr)) m_irq = 1;
            end
            if (en) m_ts = (m_ts + 1) % 65536;
        end
    endtask

    task automatic check_all();
        int head;
        head = (m_q.size() > 0) ? m_q[0] : 0;
        check("match_cnt",  32'(match_cnt),    32'(m_cnt));
        check("fifo_count", 32'(fifo_count),   32'(m_q.size()));
        check("rd_valid",   32'(rd_valid),     32'(m_q.size() > 0));
        check("rd_data",    32'(rd_data),      32'(head));
        check("overflow",   32'(overflow),     32'(m_ov));
        check("irq",        32'(irq),          32'(m_irq));
        check("rd_data_s",  32'(rd_data_s),    32'(head % 16));
        check("fifo_cnt_s", 32'(fifo_count_s), 32'(m_q.size()));
    endtask

    task automatic cycle(input bit r, input bit e, input bit d, input bit rd, input bit c);
        bit ov_before;
        bit drop;
        @(negedge clk);
        rst = r; en = e; det_in = d; rd_en = rd; clr = c;
        @(posedge clk);
        // overflow bookkeeping: clr clears the old flag, a drop now sets it
        ov_before = m_ov;
        drop = r && e && d && (m_q.size() == DEPTH) && !rd;
        model_edge();
        if (r && c) m_ov = drop;
        else if (r) m_ov = ov_before || drop;
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        cycle(0, 1, 1, 1, 1);
        check("reset_rd_data", 32'(rd_data), 32'd0);

        // Pulses at cycles 3 and 7 after reset
        for (int i = 0; i < 8; i++) cycle(1, 1, (i == 3 || i == 7), 0, 0);
        check("t1_cnt",  32'(match_cnt), 32'd2);
        check("t1_head", 32'(rd_data),   32'd3);
        cycle(1, 1, 0, 1, 0);
        check("t1_head2", 32'(rd_data), 32'd7);
        cycle(1, 1, 0, 1, 0);
        check("t1_empty", 32'(rd_valid), 32'd0);

        // Fill beyond depth, then push+pop while full
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0);
        check("t2_count", 32'(fifo_count), 32'd4);
        check("t2_ov",    32'(overflow),   32'd1);
        check("t2_cnt",   32'(match_cnt),  32'd5);
        check("t2_head",  32'(rd_data),    32'd0);
        cycle(1, 1, 1, 1, 0);
        check("t2_full_pp", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, 0);

        // Threshold interrupt
        cycle(0, 0, 0, 0, 0);
        thr = 8'd3;
        cycle(1, 1, 1, 1, 0);
        cycle(1, 1, 1, 1, 0);
        check("t3_irq_pre", 32'(irq), 32'd0);
        cycle(1, 1, 1, 1, 0);
        check("t3_irq", 32'(irq), 32'd1);
        thr = 8'd50;
        cycle(1, 1, 0, 1, 0);
        check("t3_irq_sticky", 32'(irq), 32'd1);
        cycle(1, 1, 0, 1, 1);
        check("t3_clr_irq", 32'(irq), 32'd0);
        thr = 8'd0;
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, 1, 0);
        check("t3_thr0", 32'(irq), 32'd0);

        // Saturation and clr with event, thr==1 re-fires
        for (int i = 0; i < 260; i++) cycle(1, 1, 1, 1, 0);
        check("t4_sat", 32'(match_cnt), 32'd255);
        thr = 8'd1;
        cycle(1, 1, 1, 1, 1);
        check("t4_clr_ev", 32'(match_cnt), 32'd1);
        check("t4_refire", 32'(irq), 32'd1);

        // Enable gating, then clr together with an overflow
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 1);
        check("t5_ov_clr", 32'(overflow), 32'd1);

        // Timestamp wrap on narrow instance: push+pop every cycle
        cycle(0, 0, 0, 0, 0);
        thr = 8'd0;
        for (int i = 0; i < 20; i++) cycle(1, 1, 1, 1, 0);

        // Mid-sequence reset with entries queued and irq set
        cycle(0, 0, 0, 0, 0);
        thr = 8'd2;
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check("t6_irq_set", 32'(irq), 32'd1);
        cycle(0, 1, 1, 1, 0);
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_irq",   32'(irq),        32'd0);
        cycle(1, 1, 1, 0, 0);
        check("t6_first_ts",  32'(rd_data),    32'd0);

        // Randomized traffic; thr only changes during clr cycles
        for (int i = 0; i < 3000; i++) begin
            bit c;
            c = ($urandom_range(0, 99) < 3);
            if (c) thr = 8'($urandom_range(0, 8));
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 9) != 0),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) < 3),
                  c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
